// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle instruction sequencer for the 8-bit processor.
// Fetches instruction and operand bytes over a req/ack memory port, drives
// the 5-bit ALU select and the accumulator/operand load strobes, and holds
// the program counter and a carry flag captured from the ALU.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   mem_rdata  memory read data (valid with mem_ack while mem_we=0)
//   mem_ack    completes the current access when mem_req=1
//   carry      ALU carry out
//   mem_req    access request, held until ack
//   mem_we     write qualifier (write data = ALU pass-A output)
//   mem_addr   access address
//   alu        ALU select
//   acc_ld     load accumulator from ALU output
//   b_ld       load operand register from mem_rdata
//   pc         program counter
//   halted     sequencer is in HALT
//   illegal    sticky undefined-opcode flag
//
// Parameter: RESET_PC - PC value loaded at reset.
// Build option: CTRL_ILLEGAL_TRAP_EN - when defined, opcodes 9..E trap to
// HALT and set illegal; otherwise they execute as NOP and illegal is 0.

module ctrl_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  input  logic       carry,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [4:0] alu,
  output logic       acc_ld,
  output logic       b_ld,
  output logic [7:0] pc,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_OPADDR,
    S_OPDATA,
    S_EXEC,
    S_STORE,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_INC = 4'h4;
  localparam logic [3:0] OP_LDA = 4'h5;
  localparam logic [3:0] OP_STA = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_AND  = 5'b00001;
  localparam logic [4:0] ALU_PASS = 5'b00010;
  localparam logic [4:0] ALU_LDA  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b01100;
  localparam logic [4:0] ALU_INC  = 5'b10100;

  state_t     state;
  // Only the opcode nibble of the instruction register is kept; the low
  // nibble of an instruction byte never influences behaviour.
  logic [3:0] ir_op;
  logic [7:0] oa;
  logic       c_flag;
  logic [7:0] pc_inc;

  assign pc_inc = pc + 8'd1;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_RST;
      pc     <= RESET_PC;
      ir_op  <= '0;
      oa     <= '0;
      c_flag <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_RST: state <= S_FETCH;

        S_FETCH: begin
          if (mem_ack) begin
            ir_op <= mem_rdata[7:4];
            pc    <= pc_inc;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (ir_op)
            OP_NOP: state <= S_FETCH;
            OP_INC: state <= S_EXEC;
            OP_HLT: state <= S_HALT;
            OP_ADD, OP_AND, OP_SUB, OP_LDA,
            OP_STA, OP_JMP, OP_JC: state <= S_OPADDR;
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
              illegal_q <= 1'b1;
              state     <= S_HALT;
`else
              state     <= S_FETCH;
`endif
            end
          endcase
        end

        S_OPADDR: begin
          if (mem_ack) begin
            oa <= mem_rdata;
            case (ir_op)
              OP_JMP: begin
                pc    <= mem_rdata;
                state <= S_FETCH;
              end
              OP_JC: begin
                pc    <= c_flag ? mem_rdata : pc_inc;
                state <= S_FETCH;
              end
              OP_STA: begin
                pc    <= pc_inc;
                state <= S_STORE;
              end
              default: begin
                pc    <= pc_inc;
                state <= S_OPDATA;
              end
            endcase
          end
        end

        S_OPDATA: if (mem_ack) state <= S_EXEC;

        S_EXEC: begin
          if (ir_op == OP_ADD || ir_op == OP_SUB || ir_op == OP_INC)
            c_flag <= carry;
          state <= S_FETCH;
        end

        S_STORE: if (mem_ack) state <= S_FETCH;

        S_HALT: state <= S_HALT;

        default: state <= S_RST;
      endcase
    end
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    alu      = ALU_PASS;
    acc_ld   = 1'b0;
    b_ld     = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH, S_OPADDR: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      S_OPDATA: begin
        mem_req  = 1'b1;
        mem_addr = oa;
        b_ld     = mem_ack;
      end
      S_EXEC: begin
        acc_ld = 1'b1;
        case (ir_op)
          OP_ADD:  alu = ALU_ADD;
          OP_AND:  alu = ALU_AND;
          OP_SUB:  alu = ALU_SUB;
          OP_INC:  alu = ALU_INC;
          OP_LDA:  alu = ALU_LDA;
          default: alu = ALU_PASS;
        endcase
      end
      S_STORE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = oa;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
